// File: rtl/fp_addsub_result_checker.sv
// Monitor for an FP32 add/sub unit: aligns operands with the returned result,
// classifies it, checks IEEE-754 special-case/sign rules and keeps statistics.
module fp_addsub_result_checker #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             operation_select,
    input  logic [WIDTH-1:0] result,
    input  logic             clear,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic             chk_checked,
    output logic [2:0]       res_class,
    output logic [15:0]      check_count,
    output logic [15:0]      err_count,
    output logic             err_flag,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH-1:0] first_err_result,
    output logic             first_err_op
);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_class_e;

    typedef struct packed {
        logic             valid;
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    function automatic fp_class_e classify(input logic [WIDTH-1:0] x);
        if (x[30:23] == 8'hFF) return (x[22:0] != '0) ? CLS_NAN : CLS_INF;
        if (x[30:23] == 8'h00) return (x[22:0] != '0) ? CLS_SUB : CLS_ZERO;
        return CLS_NORM;
    endfunction

    stage_t pipe [LATENCY];
    stage_t tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: in_valid, op: operation_select, a: a, b: b};
            for (int unsigned i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail = pipe[LATENCY-1];

    logic [WIDTH-1:0] op_a, op_b;
    fp_class_e        cls_a, cls_b, cls_r;
    logic             pass, checked;

    // Subtraction is folded into an addition of b with its sign flipped.
    assign op_a  = tail.a;
    assign op_b  = {tail.b[WIDTH-1] ^ ~tail.op, tail.b[WIDTH-2:0]};
    assign cls_a = classify(op_a);
    assign cls_b = classify(op_b);
    assign cls_r = classify(result);

    always_comb begin
        checked = 1'b1;
        pass    = 1'b1;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            pass = (cls_r == CLS_NAN);
        end else if (cls_a == CLS_INF && cls_b == CLS_INF && op_a[WIDTH-1] != op_b[WIDTH-1]) begin
            pass = (cls_r == CLS_NAN);
        end else if (cls_a == CLS_INF) begin
            pass = (result == op_a);
        end else if (cls_b == CLS_INF) begin
            pass = (result == op_b);
        end else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO) begin
            pass = (result == {op_a[WIDTH-1] & op_b[WIDTH-1], {(WIDTH-1){1'b0}}});
        end else if (cls_a == CLS_ZERO) begin
            pass = (result == op_b);
        end else if (cls_b == CLS_ZERO) begin
            pass = (result == op_a);
        end else if (op_a[WIDTH-1] == op_b[WIDTH-1]) begin
            pass = (result[WIDTH-1] == op_a[WIDTH-1]) && (cls_r != CLS_NAN);
        end else begin
            checked = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_valid        <= 1'b0;
            chk_pass         <= 1'b0;
            chk_checked      <= 1'b0;
            res_class        <= '0;
            check_count      <= '0;
            err_count        <= '0;
            err_flag         <= 1'b0;
            first_err_a      <= '0;
            first_err_b      <= '0;
            first_err_result <= '0;
            first_err_op     <= 1'b0;
        end else if (clear) begin
            chk_valid        <= 1'b0;
            chk_pass         <= 1'b0;
            chk_checked      <= 1'b0;
            res_class        <= '0;
            check_count      <= '0;
            err_count        <= '0;
            err_flag         <= 1'b0;
            first_err_a      <= '0;
            first_err_b      <= '0;
            first_err_result <= '0;
            first_err_op     <= 1'b0;
        end else begin
            chk_valid   <= tail.valid;
            chk_pass    <= tail.valid & pass;
            chk_checked <= tail.valid & checked;
            res_class   <= tail.valid ? cls_r : CLS_ZERO;
            if (tail.valid) begin
                if (check_count != '1) check_count <= check_count + 16'd1;
                if (!pass) begin
                    if (err_count != '1) err_count <= err_count + 16'd1;
                    // Capture holds the original b, not the sign-adjusted operand.
                    if (!err_flag) begin
                        err_flag         <= 1'b1;
                        first_err_a      <= tail.a;
                        first_err_b      <= tail.b;
                        first_err_result <= result;
                        first_err_op     <= tail.op;
                    end
                end
            end
        end
    end

endmodule
